// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with stall handshake and timeout
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] exe_inst_input,
  input  logic [31:0] alu_output,
  input  logic [31:0] store_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] data_temp,
  output logic        mem_stall,
  output logic        mem_en,
  output logic        misalign_err,
  output logic        bus_err
);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [5:0]    opc;
  logic [1:0]    off;
  logic          is_load, is_store, is_byte, is_half, is_signed;
  logic          is_mem, is_word, misaligned, accept, timeout;
  logic [CW-1:0] cnt;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_c, wdata_c;
  logic [3:0]    be_c;
  logic          unused_bits;

  assign opc         = exe_inst_input[31:26];
  assign off         = alu_output[1:0];
  assign unused_bits = ^exe_inst_input[25:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    case (opc)
      6'h20: begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      6'h21: begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      6'h23: is_load = 1'b1;
      6'h24: begin is_load = 1'b1; is_byte = 1'b1; end
      6'h25: begin is_load = 1'b1; is_half = 1'b1; end
      6'h28: begin is_store = 1'b1; is_byte = 1'b1; end
      6'h29: begin is_store = 1'b1; is_half = 1'b1; end
      6'h2B: is_store = 1'b1;
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign is_word    = is_mem & ~is_byte & ~is_half;
  assign misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign accept     = (state == IDLE) & is_mem & ~misaligned;
  assign timeout    = (state == WAIT) & ~dm_ack & (cnt == CW'(TIMEOUT_CYC - 1));

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    case (off)
      2'd0:    byte_sel = dm_rdata[31:24];
      2'd1:    byte_sel = dm_rdata[23:16];
      2'd2:    byte_sel = dm_rdata[15:8];
      default: byte_sel = dm_rdata[7:0];
    endcase
    half_sel = off[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    if (is_byte)
      load_c = {{24{is_signed & byte_sel[7]}}, byte_sel};
    else if (is_half)
      load_c = {{16{is_signed & half_sel[15]}}, half_sel};
    else
      load_c = dm_rdata;
    if (is_byte) begin
      be_c    = 4'b1000 >> off;
      wdata_c = {4{store_data[7:0]}};
    end else if (is_half) begin
      be_c    = off[1] ? 4'b0011 : 4'b1100;
      wdata_c = {2{store_data[15:0]}};
    end else begin
      be_c    = 4'b1111;
      wdata_c = store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stall is gated by rst_n so an asserted reset releases the pipeline at once.
  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: if (accept) begin
        mem_stall = rst_n;
        state_nxt = WAIT;
      end
      WAIT: begin
        mem_stall = rst_n;
        if (dm_ack || timeout) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_en = ~mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= 32'h0;
      dm_be        <= 4'h0;
      dm_wdata     <= 32'h0;
      data_temp    <= 32'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      cnt          <= '0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dm_req   <= 1'b1;
            dm_we    <= is_store;
            dm_addr  <= {alu_output[31:2], 2'b00};
            dm_be    <= be_c;
            dm_wdata <= wdata_c;
            cnt      <= '0;
          end else if (is_mem && misaligned) begin
            misalign_err <= 1'b1;
            data_temp    <= 32'h0;
          end
        end
        WAIT: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (is_load) data_temp <= load_c;
          end else if (timeout) begin
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            bus_err   <= 1'b1;
            data_temp <= 32'h0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] exe_inst_input = 32'h0;
  logic [31:0] alu_output = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h0;
  logic [31:0] data_temp;
  logic        mem_stall, mem_en, misalign_err, bus_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_dt = 32'h0;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .exe_inst_input(exe_inst_input),
    .alu_output(alu_output), .store_data(store_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .data_temp(data_temp), .mem_stall(mem_stall), .mem_en(mem_en),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ack_delay = WAIT cycle (1-based) carrying dm_ack; 0 means never ack.
  task automatic do_op(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdata, input int ack_delay, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    logic        st;
    logic        to;
    logic [31:0] exp_dt;
    int          wc;
    st     = opc[3];
    to     = (ack_delay <= 0) || (ack_delay > TO);
    exp_dt = to ? 32'h0 : (st ? model_dt : exp_load);
    wc     = 0;
    exe_inst_input = {opc, 26'h0};
    alu_output     = addr;
    store_data     = sdata;
    dm_ack         = 1'b0;
    exp_q.push_back(exp_dt);
    #1;
    check("idle_stall", 32'(mem_stall), 32'd1);
    tick;
    check("req", 32'(dm_req), 32'd1);
    check("we", 32'(dm_we), 32'(st));
    check("addr", dm_addr, {addr[31:2], 2'b00});
    check("be", 32'(dm_be), 32'(exp_be));
    if (st) check("wdata", dm_wdata, exp_wdata);
    while (mem_stall && wc < 4 * TO) begin
      wc++;
      check("wait_req", 32'(dm_req), 32'd1);
      if (wc == ack_delay) begin
        dm_ack   = 1'b1;
        dm_rdata = rdata;
      end
      tick;
      dm_ack = 1'b0;
    end
    check("stall_cycles", 32'(1 + wc), 32'(1 + (to ? TO : ack_delay)));
    check("done_en", 32'(mem_en), 32'd1);
    check("done_req", 32'(dm_req), 32'd0);
    check("done_we", 32'(dm_we), 32'd0);
    check("bus_err", 32'(bus_err), 32'(to));
    check("data_temp", data_temp, exp_q.pop_front());
    model_dt = exp_dt;
    exe_inst_input = 32'h0;
    tick;
    check("post_bus_err", 32'(bus_err), 32'd0);
    check("post_stall", 32'(mem_stall), 32'd0);
  endtask

  task automatic do_misalign(input logic [5:0] opc, input logic [31:0] addr);
    exe_inst_input = {opc, 26'h0};
    alu_output     = addr;
    #1;
    check("mis_stall", 32'(mem_stall), 32'd0);
    tick;
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_req", 32'(dm_req), 32'd0);
    check("mis_dt", data_temp, 32'h0);
    model_dt = 32'h0;
    exe_inst_input = 32'h0;
    tick;
    check("mis_pulse", 32'(misalign_err), 32'd0);
  endtask

  initial begin
    tick;
    tick;
    check("rst_req", 32'(dm_req), 32'd0);
    check("rst_dt", data_temp, 32'h0);
    check("rst_be", 32'(dm_be), 32'd0);
    rst_n = 1'b1;

    do_op(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4'b1111, 32'h0, 32'hDEADBEEF);
    do_op(6'h20, 32'h103, 32'h0, 32'h112233F0, 1, 4'b0001, 32'h0, 32'hFFFFFFF0);
    do_op(6'h24, 32'h103, 32'h0, 32'h112233F0, 2, 4'b0001, 32'h0, 32'h000000F0);
    do_op(6'h21, 32'h102, 32'h0, 32'h12348001, 1, 4'b0011, 32'h0, 32'hFFFF8001);
    do_op(6'h25, 32'h100, 32'h0, 32'h80011234, 1, 4'b1100, 32'h0, 32'h00008001);
    do_op(6'h29, 32'h202, 32'h0000ABCD, 32'h0, 2, 4'b0011, 32'hABCDABCD, 32'h0);
    do_op(6'h28, 32'h301, 32'h0000005A, 32'h0, 1, 4'b0100, 32'h5A5A5A5A, 32'h0);

    exe_inst_input = {6'h08, 26'h0};
    alu_output     = 32'h100;
    #1;
    check("nonmem_stall", 32'(mem_stall), 32'd0);
    tick;
    check("nonmem_req", 32'(dm_req), 32'd0);
    check("nonmem_dt", data_temp, model_dt);

    exe_inst_input = 32'h0;
    dm_ack   = 1'b1;
    dm_rdata = 32'h55AA55AA;
    tick;
    dm_ack = 1'b0;
    check("idle_ack_dt", data_temp, model_dt);
    check("idle_ack_req", 32'(dm_req), 32'd0);

    do_misalign(6'h23, 32'h101);
    do_misalign(6'h21, 32'h103);

    do_op(6'h23, 32'h120, 32'h0, 32'hCAFEF00D, TO, 4'b1111, 32'h0, 32'hCAFEF00D);
    do_op(6'h23, 32'h124, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h0);

    do_op(6'h23, 32'h128, 32'h0, 32'h13572468, 1, 4'b1111, 32'h0, 32'h13572468);
    exe_inst_input = {6'h23, 26'h0};
    alu_output     = 32'h400;
    exp_q.push_back(32'h0BADF00D);
    tick;
    tick;
    check("pre_rst_req", 32'(dm_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(dm_req), 32'd0);
    check("arst_addr", dm_addr, 32'h0);
    check("arst_dt", data_temp, 32'h0);
    check("arst_stall", 32'(mem_stall), 32'd0);
    exp_q.delete();
    model_dt = 32'h0;
    tick;
    rst_n = 1'b1;
    exe_inst_input = 32'h0;
    dm_ack   = 1'b1;
    dm_rdata = 32'hFFFFFFFF;
    tick;
    dm_ack = 1'b0;
    check("stray_dt", data_temp, 32'h0);
    check("stray_req", 32'(dm_req), 32'd0);
    do_op(6'h2B, 32'h300, 32'h12345678, 32'h0, 1, 4'b1111, 32'h12345678, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
